// File: rtl/epb_pkg.sv
// epb_pkg: shared widths and FSM encoding for the EPB-to-Wishbone bridge
package epb_pkg;
    localparam int EPB_DW  = 16;
    localparam int EPB_AW  = 23;
    localparam int EPB_GPW = 6;
    localparam int EPB_BEW = 2;
    localparam int WB_AW   = 32;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } epb_state_e;
endpackage

// File: rtl/epb_sync2.sv
// epb_sync2: W-bit two-flop synchronizer that resets to all ones
module epb_sync2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    // two-stage resynchronization into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/epb_wb_bridge.sv
// epb_wb_bridge: one EPB access becomes one 16-bit Wishbone classic cycle with timeout
module epb_wb_bridge
    import epb_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 1023,
    parameter logic [EPB_DW-1:0] TIMEOUT_DATA   = 16'hDEAD
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               epb_cs_n,
    input  logic               epb_r_w_n,
    input  logic [EPB_BEW-1:0] epb_be_n,
    input  logic [EPB_AW-1:0]  epb_addr,
    input  logic [EPB_GPW-1:0] epb_addr_gp,
    input  logic [EPB_DW-1:0]  epb_data_in,
    output logic [EPB_DW-1:0]  epb_data_out,
    output logic               epb_data_oe_n,
    output logic               epb_rdy,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [EPB_BEW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [EPB_DW-1:0]  wbm_dat_o,
    input  logic [EPB_DW-1:0]  wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic               timeout_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    epb_state_e         state, state_nxt;
    logic               cs_s, rw_s, rd, rd_nxt;
    logic [1:0]         flush;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               cyc_nxt, we_nxt, oe_n_nxt, rdy_nxt, timeout_nxt, done, good;
    logic [EPB_BEW-1:0] sel_nxt;
    logic [WB_AW-1:0]   adr_nxt;
    logic [EPB_DW-1:0]  dat_nxt, data_out_nxt;

    epb_sync2 #(.W(2)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   ({epb_cs_n, epb_r_w_n}),
        .q   ({cs_s, rw_s})
    );

    assign good = wbm_ack_i & ~wbm_err_i;
    assign done = wbm_ack_i | wbm_err_i | (cnt == CW'(TIMEOUT_CYCLES - 1));

    // next-state and next-output decode; every register holds unless its state acts on it
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_nxt       = rd;
        cyc_nxt      = wbm_cyc_o;
        we_nxt       = wbm_we_o;
        sel_nxt      = wbm_sel_o;
        adr_nxt      = wbm_adr_o;
        dat_nxt      = wbm_dat_o;
        data_out_nxt = epb_data_out;
        oe_n_nxt     = epb_data_oe_n;
        rdy_nxt      = epb_rdy;
        timeout_nxt  = timeout_o;
        case (state)
            IDLE: if (!cs_s) begin
                state_nxt = BUS;
                cnt_nxt   = '0;
                rd_nxt    = rw_s;
                cyc_nxt   = 1'b1;
                we_nxt    = ~rw_s;
                sel_nxt   = ~epb_be_n;
                adr_nxt   = {2'b00, epb_addr_gp, epb_addr, 1'b0};
                dat_nxt   = epb_data_in;
            end
            BUS: if (done) begin
                state_nxt    = RESP;
                cyc_nxt      = 1'b0;
                data_out_nxt = good ? (rd ? wbm_dat_i : epb_data_out) : TIMEOUT_DATA;
                timeout_nxt  = timeout_o | ~(wbm_ack_i | wbm_err_i);
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
            RESP: begin
                state_nxt = RELEASE;
                rdy_nxt   = 1'b1;
                oe_n_nxt  = ~rd;
            end
            RELEASE: if (cs_s && flush[1]) begin
                state_nxt = IDLE;
                rdy_nxt   = 1'b0;
                oe_n_nxt  = 1'b1;
            end
        endcase
    end

    // state and output registers; flush keeps RELEASE from trusting the synchronizer's reset value
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= RELEASE;
            flush         <= 2'b00;
            cnt           <= '0;
            rd            <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_sel_o     <= '0;
            wbm_adr_o     <= '0;
            wbm_dat_o     <= '0;
            epb_data_out  <= '0;
            epb_data_oe_n <= 1'b1;
            epb_rdy       <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush         <= {flush[0], 1'b1};
            cnt           <= cnt_nxt;
            rd            <= rd_nxt;
            wbm_cyc_o     <= cyc_nxt;
            wbm_we_o      <= we_nxt;
            wbm_sel_o     <= sel_nxt;
            wbm_adr_o     <= adr_nxt;
            wbm_dat_o     <= dat_nxt;
            epb_data_out  <= data_out_nxt;
            epb_data_oe_n <= oe_n_nxt;
            epb_rdy       <= rdy_nxt;
            timeout_o     <= timeout_nxt;
        end
    end

    assign wbm_stb_o = wbm_cyc_o;
endmodule
